// File: rtl/sun_pll_ctrl.sv
// SUN_PLL power-up / lock sequencer: bias settle, core power-up, lock qualification, retry/fail.
// Optional auto-relock on loss of lock is built when SUN_PLL_CTRL_AUTORELOCK_EN is defined.
//
// state  | meaning
// OFF    | everything off, counters cleared, waiting for EN
// BIAS   | bias/CP current on, settling
// START  | core power-up, KICK/LPF precharge fires (one cycle)
// ACQ    | waiting for a qualified run of synced lock
// LOCKED | lock qualified, output clock enabled
// RETRY  | core powered down for a settle period before another attempt
// FAIL   | retries exhausted, held until EN drops
module sun_pll_ctrl #(
  parameter int SETTLE_CYC  = 64,
  parameter int LOCK_CYC    = 256,
  parameter int TIMEOUT_CYC = 4096,
  parameter int MAX_RETRY   = 3,
  parameter int LOSS_CYC    = 4,
  parameter int CW          = 13
) (
  input  logic       CK_REF,
  input  logic       RST,
  input  logic       EN,
  input  logic       LOCK_RAW,
  output logic       BIAS_EN,
  output logic       PWRUP_1V8,
  output logic       CK_EN,
  output logic       LOCKED,
  output logic       FAIL,
  output logic [1:0] RETRY_CNT,
  output logic [2:0] STATE
);

  localparam logic [2:0] S_OFF    = 3'd0;
  localparam logic [2:0] S_BIAS   = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_ACQ    = 3'd3;
  localparam logic [2:0] S_LOCKED = 3'd4;
  localparam logic [2:0] S_RETRY  = 3'd5;
  localparam logic [2:0] S_FAIL   = 3'd6;

  localparam int LW = $clog2(LOCK_CYC + 1);

  localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [LW-1:0] LOCK_LAST    = LW'(LOCK_CYC - 1);
  localparam logic [1:0]    RETRY_MAX    = 2'(MAX_RETRY);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] timer_q, timer_d;
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  logic [1:0]    retry_q, retry_d;
  logic [1:0]    lk_sync_q, lk_sync_d;
  logic          bias_en_q, bias_en_d;
  logic          pwrup_q, pwrup_d;
  logic          ck_en_q, ck_en_d;
  logic          locked_q, locked_d;
  logic          fail_q, fail_d;
  logic          lk;
  logic          change;

  assign lk = lk_sync_q[1];

`ifdef SUN_PLL_CTRL_AUTORELOCK_EN
  localparam int LSW = $clog2(LOSS_CYC + 1);
  localparam logic [LSW-1:0] LOSS_LAST = LSW'(LOSS_CYC - 1);
  logic [LSW-1:0] loss_cnt_q, loss_cnt_d;
`endif

  always_comb begin
    lk_sync_d = {lk_sync_q[0], LOCK_RAW};
    state_d   = state_q;
    case (state_q)
      S_OFF:    if (EN) state_d = S_BIAS;
      S_BIAS:   if (timer_q == SETTLE_LAST) state_d = S_START;
      S_START:  state_d = S_ACQ;
      S_ACQ: begin
        // lock wins over a timeout landing on the same cycle
        if (lk && lock_cnt_q == LOCK_LAST)
          state_d = S_LOCKED;
        else if (timer_q == TIMEOUT_LAST)
          state_d = (retry_q < RETRY_MAX) ? S_RETRY : S_FAIL;
      end
      S_RETRY:  if (timer_q == SETTLE_LAST) state_d = S_START;
      S_LOCKED: begin
`ifdef SUN_PLL_CTRL_AUTORELOCK_EN
        if (!lk && loss_cnt_q == LOSS_LAST) state_d = S_ACQ;
`endif
      end
      S_FAIL:   state_d = S_FAIL;
      default:  state_d = S_OFF;
    endcase
    if (!EN) state_d = S_OFF;

    change = (state_d != state_q);

    timer_d = '0;
    if (!change && (state_q == S_BIAS || state_q == S_ACQ || state_q == S_RETRY))
      timer_d = timer_q + 1'b1;

    lock_cnt_d = '0;
    if (!change && state_q == S_ACQ && lk)
      lock_cnt_d = lock_cnt_q + 1'b1;

`ifdef SUN_PLL_CTRL_AUTORELOCK_EN
    loss_cnt_d = '0;
    if (!change && state_q == S_LOCKED && !lk)
      loss_cnt_d = loss_cnt_q + 1'b1;
`endif

    retry_d = retry_q;
    if (state_d == S_OFF)
      retry_d = '0;
    else if (change && state_d == S_RETRY && retry_q < RETRY_MAX)
      retry_d = retry_q + 1'b1;

    // outputs are decoded from the next state so they line up with STATE
    bias_en_d = 1'b0;
    pwrup_d   = 1'b0;
    ck_en_d   = 1'b0;
    locked_d  = 1'b0;
    fail_d    = 1'b0;
    case (state_d)
      S_BIAS, S_RETRY: bias_en_d = 1'b1;
      S_START, S_ACQ: begin
        bias_en_d = 1'b1;
        pwrup_d   = 1'b1;
      end
      S_LOCKED: begin
        bias_en_d = 1'b1;
        pwrup_d   = 1'b1;
        ck_en_d   = 1'b1;
        locked_d  = 1'b1;
      end
      S_FAIL:  fail_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CK_REF) begin
    if (RST) begin
      state_q    <= S_OFF;
      timer_q    <= '0;
      lock_cnt_q <= '0;
      retry_q    <= '0;
      lk_sync_q  <= '0;
      bias_en_q  <= 1'b0;
      pwrup_q    <= 1'b0;
      ck_en_q    <= 1'b0;
      locked_q   <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      lock_cnt_q <= lock_cnt_d;
      retry_q    <= retry_d;
      lk_sync_q  <= lk_sync_d;
      bias_en_q  <= bias_en_d;
      pwrup_q    <= pwrup_d;
      ck_en_q    <= ck_en_d;
      locked_q   <= locked_d;
      fail_q     <= fail_d;
    end
  end

`ifdef SUN_PLL_CTRL_AUTORELOCK_EN
  always_ff @(posedge CK_REF) begin
    if (RST) loss_cnt_q <= '0;
    else     loss_cnt_q <= loss_cnt_d;
  end
`endif

  assign BIAS_EN   = bias_en_q;
  assign PWRUP_1V8 = pwrup_q;
  assign CK_EN     = ck_en_q;
  assign LOCKED    = locked_q;
  assign FAIL      = fail_q;
  assign RETRY_CNT = retry_q;
  assign STATE     = state_q;

endmodule

// File: tb/tb_sun_pll_ctrl.sv
// Directed bench for sun_pll_ctrl with short timing parameters.
// Loss-of-lock expectations follow SUN_PLL_CTRL_AUTORELOCK_EN when it is defined.
module tb_sun_pll_ctrl;

  logic       ck_ref = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       lock_raw = 1'b0;
  logic       bias_en, pwrup_1v8, ck_en, locked, fail;
  logic [1:0] retry_cnt;
  logic [2:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  sun_pll_ctrl #(
    .SETTLE_CYC(4), .LOCK_CYC(8), .TIMEOUT_CYC(32), .MAX_RETRY(2), .LOSS_CYC(4), .CW(13)
  ) dut (
    .CK_REF(ck_ref), .RST(rst), .EN(en), .LOCK_RAW(lock_raw),
    .BIAS_EN(bias_en), .PWRUP_1V8(pwrup_1v8), .CK_EN(ck_en), .LOCKED(locked),
    .FAIL(fail), .RETRY_CNT(retry_cnt), .STATE(state)
  );

  always #5 ck_ref = ~ck_ref;

  // outs = {BIAS_EN, PWRUP_1V8, CK_EN, LOCKED, FAIL}
  localparam logic [4:0] O_OFF    = 5'b00000;
  localparam logic [4:0] O_BIAS   = 5'b10000;
  localparam logic [4:0] O_PWR    = 5'b11000;
  localparam logic [4:0] O_LOCKED = 5'b11110;
  localparam logic [4:0] O_FAIL   = 5'b00001;

  function automatic logic [9:0] obs();
    return {bias_en, pwrup_1v8, ck_en, locked, fail, retry_cnt, state};
  endfunction

  function automatic logic [9:0] ev(logic [4:0] outs, logic [1:0] rc, logic [2:0] st);
    return {outs, rc, st};
  endfunction

  task automatic chk(string tag, logic [9:0] got, logic [9:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge ck_ref);
    #1;
  endtask

  // Raise EN and walk BIAS -> START -> ACQ cycle by cycle; returns one edge into ACQ.
  task automatic bias_start();
    en = 1'b1;
    tick(1);
    chk("bias_enter", obs(), ev(O_BIAS, 2'd0, 3'd1));
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("bias_hold", obs(), ev(O_BIAS, 2'd0, 3'd1));
    end
    tick(1);
    chk("start", obs(), ev(O_PWR, 2'd0, 3'd2));
    tick(1);
    chk("acq_enter", obs(), ev(O_PWR, 2'd0, 3'd3));
  endtask

  initial begin
    // reset
    tick(2);
    chk("reset", obs(), ev(O_OFF, 2'd0, 3'd0));
    rst = 1'b0;
    tick(1);
    chk("off_idle", obs(), ev(O_OFF, 2'd0, 3'd0));

    // steady lock raised at ACQ entry: LOCKED 11 cycles after START
    bias_start();
    lock_raw = 1'b1;
    tick(9);
    chk("lock_early", obs(), ev(O_PWR, 2'd0, 3'd3));
    tick(1);
    chk("lock_on_time", obs(), ev(O_LOCKED, 2'd0, 3'd4));

    // loss of lock for 4 raw cycles
    lock_raw = 1'b0;
    tick(4);
    lock_raw = 1'b1;
    tick(1);
    chk("loss_hold", obs(), ev(O_LOCKED, 2'd0, 3'd4));
    tick(1);
`ifdef SUN_PLL_CTRL_AUTORELOCK_EN
    chk("loss_relock", obs(), ev(O_PWR, 2'd0, 3'd3));
`else
    chk("loss_sticky", obs(), ev(O_LOCKED, 2'd0, 3'd4));
`endif
    en = 1'b0;
    lock_raw = 1'b0;
    tick(1);
    chk("en_off_1", obs(), ev(O_OFF, 2'd0, 3'd0));

    // lock dip: 7 high, 1 low, then high -> lock 18 edges after ACQ entry
    bias_start();
    lock_raw = 1'b1;
    tick(7);
    lock_raw = 1'b0;
    tick(1);
    lock_raw = 1'b1;
    tick(9);
    chk("dip_no_lock", obs(), ev(O_PWR, 2'd0, 3'd3));
    tick(1);
    chk("dip_lock", obs(), ev(O_LOCKED, 2'd0, 3'd4));
    en = 1'b0;
    lock_raw = 1'b0;
    tick(1);
    chk("en_off_2", obs(), ev(O_OFF, 2'd0, 3'd0));

    // no lock: two retries, then FAIL
    bias_start();
    for (int r = 1; r <= 2; r++) begin
      tick(31);
      chk("acq_before_to", obs(), ev(O_PWR, 2'(r - 1), 3'd3));
      tick(1);
      chk("retry_enter", obs(), ev(O_BIAS, 2'(r), 3'd5));
      tick(3);
      chk("retry_hold", obs(), ev(O_BIAS, 2'(r), 3'd5));
      tick(1);
      chk("retry_start", obs(), ev(O_PWR, 2'(r), 3'd2));
      tick(1);
      chk("retry_acq", obs(), ev(O_PWR, 2'(r), 3'd3));
    end
    tick(31);
    chk("acq_last", obs(), ev(O_PWR, 2'd2, 3'd3));
    tick(1);
    chk("fail_enter", obs(), ev(O_FAIL, 2'd2, 3'd6));
    tick(5);
    chk("fail_sticky", obs(), ev(O_FAIL, 2'd2, 3'd6));
    en = 1'b0;
    tick(1);
    chk("fail_clear", obs(), ev(O_OFF, 2'd0, 3'd0));

    // EN drop mid-ACQ, then a clean restart
    bias_start();
    tick(5);
    chk("acq_mid", obs(), ev(O_PWR, 2'd0, 3'd3));
    en = 1'b0;
    tick(1);
    chk("en_drop_acq", obs(), ev(O_OFF, 2'd0, 3'd0));
    bias_start();

    // RST during RETRY, then a clean restart
    tick(32);
    chk("retry_pre_rst", obs(), ev(O_BIAS, 2'd1, 3'd5));
    tick(1);
    rst = 1'b1;
    tick(1);
    chk("rst_in_retry", obs(), ev(O_OFF, 2'd0, 3'd0));
    rst = 1'b0;
    bias_start();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
